shrink32: RTL and testbench

//  Receive end of the 32-clock stretched-pulse link. Takes a wide pulse that may

---
 rtl/shrink32.sv | 138 +++++++++++++
 tb/tb_shrink32.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/shrink32.sv
// Receive end of the stretched-pulse link: synchronizes w, qualifies its width, emits n / e_short / e_long.
// Optional PULSE_COUNT_EN adds a 16-bit wrapping count of accepted pulses on port cnt.
module shrink32 #(
  parameter int SYNC = 2,
  parameter int MINW = 24,
  parameter int MAXW = 40,
  parameter int GAP  = 4
) (
  input  logic        c,
  input  logic        rn,
  input  logic        w,
  output logic        n,
  output logic        e_short,
  output logic        e_long,
  output logic        busy
`ifdef PULSE_COUNT_EN
  ,
  output logic [15:0] cnt
`endif
);

  localparam int CW = $clog2(MAXW + 2);

  typedef enum logic [2:0] {IDLE, QUAL, ACTIVE, STUCK, GAPW} state_t;

  state_t          state, state_next;
  logic [SYNC-1:0] sync;
  logic            ws;
  logic [CW-1:0]   count, count_next, count_inc;
  logic            n_next, es_next, el_next;

  assign ws = sync[SYNC-1];

  always_ff @(posedge c or negedge rn) begin
    if (!rn) sync <= '0;
    else     sync <= {sync[SYNC-2:0], w};
  end

  // Saturating increment: the counter never wraps back into a legal window.
  assign count_inc = (count == '1) ? count : count + 1'b1;

  always_comb begin
    state_next = state;
    count_next = count;
    n_next     = 1'b0;
    es_next    = 1'b0;
    el_next    = 1'b0;
    case (state)
      IDLE: begin
        if (ws) begin
          if (MINW == 1) begin
            state_next = ACTIVE;
            count_next = CW'(MINW);
            n_next     = 1'b1;
          end else begin
            state_next = QUAL;
            count_next = CW'(1);
          end
        end
      end
      QUAL: begin
        if (ws) begin
          if (count_inc == CW'(MINW)) begin
            state_next = ACTIVE;
            count_next = CW'(MINW);
            n_next     = 1'b1;
          end else begin
            count_next = count_inc;
          end
        end else begin
          state_next = GAPW;
          count_next = CW'(1);
          es_next    = 1'b1;
        end
      end
      ACTIVE: begin
        if (ws) begin
          if (count == CW'(MAXW)) begin
            state_next = STUCK;
            el_next    = 1'b1;
          end else begin
            count_next = count_inc;
          end
        end else begin
          state_next = GAPW;
          count_next = CW'(1);
        end
      end
      STUCK: begin
        if (!ws) begin
          state_next = GAPW;
          count_next = CW'(1);
        end
      end
      GAPW: begin
        // Any high sample restarts the low-run requirement.
        if (ws) begin
          count_next = '0;
        end else if (count == CW'(GAP)) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count_inc;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      state   <= IDLE;
      count   <= '0;
      n       <= 1'b0;
      e_short <= 1'b0;
      e_long  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      n       <= n_next;
      e_short <= es_next;
      e_long  <= el_next;
      busy    <= (state_next != IDLE);
    end
  end

`ifdef PULSE_COUNT_EN
  always_ff @(posedge c or negedge rn) begin
    if (!rn)         cnt <= '0;
    else if (n_next) cnt <= cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_shrink32.sv
// Self-checking bench for shrink32: directed scenarios plus randomized pulses against a run-length model.
// Build with PULSE_COUNT_EN defined to also exercise the cnt output and its wrap.
module tb_shrink32;

  localparam int SYNC = 2;
  localparam int MINW = 24;
  localparam int MAXW = 40;
  localparam int GAP  = 4;

  logic c = 1'b0;
  logic rn = 1'b0;
  logic w = 1'b0;
  logic n, e_short, e_long, busy;
`ifdef PULSE_COUNT_EN
  logic [15:0] cnt;
`endif

  shrink32 #(.SYNC(SYNC), .MINW(MINW), .MAXW(MAXW), .GAP(GAP)) dut (
    .c(c), .rn(rn), .w(w), .n(n), .e_short(e_short), .e_long(e_long), .busy(busy)
`ifdef PULSE_COUNT_EN
    , .cnt(cnt)
`endif
  );

  always #5 c = ~c;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: tracks runs of high and low synchronized samples.
  logic        exp_n = 1'b0, exp_es = 1'b0, exp_el = 1'b0, m_busy = 1'b0;
  logic [15:0] m_pc = '0;
  int          m_ncount = 0;
  int          hr = 0, lr = 0;
  int          cyc = 0;
  logic        hist[$];

  always @(posedge c or negedge rn) begin
    logic s;
    if (!rn) begin
      hist.delete();
      exp_n = 1'b0; exp_es = 1'b0; exp_el = 1'b0;
      m_busy = 1'b0; hr = 0; lr = 0; m_pc = '0;
    end else begin
      cyc++;
      hist.push_back(w);
      s = (hist.size() > SYNC) ? hist.pop_front() : 1'b0;
      exp_n = 1'b0; exp_es = 1'b0; exp_el = 1'b0;
      if (!m_busy) begin
        if (s) begin
          m_busy = 1'b1; hr = 1; lr = 0;
          if (MINW == 1) exp_n = 1'b1;
        end
      end else if (hr > 0) begin
        if (s) begin
          hr++;
          if (hr == MINW)     exp_n  = 1'b1;
          if (hr == MAXW + 1) exp_el = 1'b1;
        end else begin
          if (hr < MINW) exp_es = 1'b1;
          hr = 0; lr = 1;
        end
      end else begin
        if (s) lr = 0;
        else begin
          lr++;
          if (lr == GAP + 1) m_busy = 1'b0;
        end
      end
      if (exp_n) begin
        m_pc = m_pc + 16'd1;
        m_ncount++;
      end
    end
  end

  int obs_n = 0, obs_es = 0, obs_el = 0;
  int first_n_cyc = 0, es_cyc = 0, el_cyc = 0, rise_cyc = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("n", {15'd0, n}, {15'd0, exp_n});
    chk("e_short", {15'd0, e_short}, {15'd0, exp_es});
    chk("e_long", {15'd0, e_long}, {15'd0, exp_el});
    chk("busy", {15'd0, busy}, {15'd0, m_busy});
`ifdef PULSE_COUNT_EN
    chk("cnt", cnt, m_pc);
`endif
    if (n === 1'b1) begin
      if (obs_n == 0) first_n_cyc = cyc;
      obs_n++;
    end
    if (e_short === 1'b1) begin obs_es++; es_cyc = cyc; end
    if (e_long === 1'b1)  begin obs_el++; el_cyc = cyc; end
  endtask

  task automatic step_off(input logic v, input int off);
    @(posedge c);
    #(off);
    if (v && !w) rise_cyc = cyc;
    w = v;
    @(negedge c);
    chk_outputs();
  endtask

  task automatic step(input logic v);
    step_off(v, 2);
  endtask

  task automatic pulse(input int hi, input int lo);
    repeat (hi) step(1'b1);
    repeat (lo) step(1'b0);
  endtask

  task automatic clear_obs();
    obs_n = 0; obs_es = 0; obs_el = 0;
  endtask

  initial begin
    int base;
    rn = 1'b0;
    w  = 1'b0;
    @(negedge c);
    chk("reset_n", {15'd0, n}, 16'd0);
    chk("reset_busy", {15'd0, busy}, 16'd0);
    repeat (2) @(posedge c);
    #3 rn = 1'b1;
    repeat (6) step(1'b0);

    // 1: nominal 32-cycle pulse
    clear_obs();
    pulse(32, 12);
    chk("t1_n_count", 16'(obs_n), 16'd1);
    chk("t1_n_edge", 16'(first_n_cyc - rise_cyc), 16'(SYNC + MINW));
    chk("t1_err_count", 16'(obs_es + obs_el), 16'd0);
    chk("t1_busy_end", {15'd0, busy}, 16'd0);

    // 2: short pulse
    clear_obs();
    pulse(10, 12);
    chk("t2_es_count", 16'(obs_es), 16'd1);
    chk("t2_es_edge", 16'(es_cyc - rise_cyc), 16'(SYNC + 10 + 1));
    chk("t2_n_count", 16'(obs_n), 16'd0);

    // 3: stuck-high pulse
    clear_obs();
    repeat (100) step(1'b1);
    chk("t3_busy_high", {15'd0, busy}, 16'd1);
    repeat (12) step(1'b0);
    chk("t3_n_count", 16'(obs_n), 16'd1);
    chk("t3_n_edge", 16'(first_n_cyc - rise_cyc), 16'(SYNC + MINW));
    chk("t3_el_count", 16'(obs_el), 16'd1);
    chk("t3_el_edge", 16'(el_cyc - rise_cyc), 16'(SYNC + MAXW + 1));
    chk("t3_busy_end", {15'd0, busy}, 16'd0);

    // 4: back-to-back pulses with short and sufficient gaps
    clear_obs();
    pulse(32, 2);
    pulse(32, 12);
    chk("t4_short_gap_n", 16'(obs_n), 16'd1);
    clear_obs();
    pulse(32, 6);
    pulse(32, 12);
    chk("t4_long_gap_n", 16'(obs_n), 16'd2);

    // 5: reset in the middle of a pulse, w stays high through release
    repeat (20) step(1'b1);
    #1 rn = 1'b0;
    #1;
    chk("t5_n_async", {15'd0, n}, 16'd0);
    chk("t5_busy_async", {15'd0, busy}, 16'd0);
    chk("t5_es_async", {15'd0, e_short}, 16'd0);
    chk("t5_el_async", {15'd0, e_long}, 16'd0);
    repeat (2) step(1'b1);
    @(posedge c);
    #3 rn = 1'b1;
    clear_obs();
    pulse(10, 12);
    chk("t5_es_after", 16'(obs_es), 16'd1);
    chk("t5_n_after", 16'(obs_n), 16'd0);

`ifdef PULSE_COUNT_EN
    // 6a: counter wrap
    @(negedge c);
    force dut.cnt = 16'hFFFF;
    m_pc = 16'hFFFF;
    #1 release dut.cnt;
    pulse(32, 12);
    chk("t6_cnt_wrap", cnt, 16'h0000);
`endif

    // 6b: randomized widths/gaps with jittered edge timing
    clear_obs();
    base = m_ncount;
    for (int i = 0; i < 40; i++) begin
      int hi, lo;
      hi = $urandom_range(44, 20);
      lo = $urandom_range(10, 1);
      repeat (hi) step_off(1'b1, $urandom_range(4, 1));
      repeat (lo) step_off(1'b0, $urandom_range(4, 1));
    end
    repeat (12) step(1'b0);
    chk("t6_rand_n_count", 16'(obs_n), 16'(m_ncount - base));
    chk("t6_rand_idle", {15'd0, busy}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
